// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] MIPS_NOP         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

endpackage

// File: rtl/mips_ifid_reg.sv
// IF/ID pipeline register: instruction word, its PC and a valid flag; resets to NOP.
module mips_ifid_reg
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic              i_consume,
  input  logic [31:0]       i_instr,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              o_valid,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_pc
);

  logic              r_valid;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pc;

  // Flush wins over load; a consumed entry drops valid unless refilled the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= MIPS_NOP;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, hold buffer, IF/ID.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [5:0]        op,
`ifdef FETCH_PERF_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
`endif
  output logic [5:0]        funct
);

  fetch_state_t      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic              r_kill, w_kill_nxt;
  logic [31:0]       r_hold;
  logic              w_load, w_hold_load, w_flush, w_stall;
  logic [31:0]       w_load_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
      r_hold  <= MIPS_NOP;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
      if (w_hold_load) r_hold <= imem_rdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_load      = 1'b0;
    w_hold_load = 1'b0;
    w_flush     = 1'b0;
    imem_req    = 1'b0;
    unique case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          w_state_nxt = REQ;
          if (r_kill) begin
            w_kill_nxt = 1'b0;
          end else if (!instr_valid || id_ready) begin
            w_load   = 1'b1;
            w_pc_nxt = r_pc + ADDR_W'(4);
          end else begin
            w_hold_load = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (id_ready) begin
          w_load      = 1'b1;
          w_pc_nxt    = r_pc + ADDR_W'(4);
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // A granted or outstanding request cannot be recalled, so it is tagged to be dropped.
    if (redirect_valid) begin
      w_pc_nxt    = redirect_pc & ~ADDR_W'(3);
      w_flush     = 1'b1;
      w_load      = 1'b0;
      w_hold_load = 1'b0;
      w_state_nxt = REQ;
      if (r_state == REQ && imem_gnt) begin
        w_kill_nxt  = 1'b1;
        w_state_nxt = WAIT;
      end else if (r_state == WAIT) begin
        w_kill_nxt  = !imem_rvalid;
        w_state_nxt = imem_rvalid ? REQ : WAIT;
      end
    end
  end

  assign w_load_data = (r_state == HOLD) ? r_hold : imem_rdata;
  assign w_stall     = (r_state == REQ  && !imem_gnt)
                    || (r_state == WAIT && !imem_rvalid)
                    || (r_state == HOLD);

  mips_ifid_reg #(.ADDR_W(ADDR_W)) u_ifid (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_flush   (w_flush),
    .i_consume (instr_valid && id_ready),
    .i_instr   (w_load_data),
    .i_pc      (r_pc),
    .o_valid   (instr_valid),
    .o_instr   (instr),
    .o_pc      (instr_pc)
  );

  assign imem_addr = r_pc;
  assign pc_plus4  = instr_pc + ADDR_W'(4);
  assign op        = instr[OP_MSB:OP_LSB];
  assign funct     = instr[FUNCT_MSB:FUNCT_LSB];

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_load  && r_perf_fetched != '1) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_stall && r_perf_stall   != '1) r_perf_stall   <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`else
  logic w_unused_stall;
  assign w_unused_stall = w_stall;
`endif

endmodule
